// File: rtl/comma_align_pkg.sv
// Shared K28.5 patterns, alignment FSM state type and comma match helper.
// Combinational helper only; no latency, no flow control.
package comma_align_pkg;

    localparam int OFF_W = 4;
    localparam int SYM_C = 10;

    localparam logic [SYM_C-1:0] K28P_C = 10'b0011111010;
    localparam logic [SYM_C-1:0] K28N_C = 10'b1100000101;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        CHECK    = 2'd1,
        LOCKED   = 2'd2
    } align_state_t;

    function automatic logic is_comma(input logic [SYM_C-1:0] sym);
        return (sym == K28P_C) || (sym == K28N_C);
    endfunction

endpackage

// File: rtl/comma_search.sv
// Scans all ten bit offsets of the 20-bit window for K28.5 of either disparity.
// Purely combinational; lowest hitting offset wins; no flow control.
module comma_search
    import comma_align_pkg::*;
(
    input  logic [2*SYM_C-1:0] window_i,
    input  logic [OFF_W-1:0]   align_offset_i,
    output logic               hit_any_o,
    output logic [OFF_W-1:0]   hit_off_o,
    output logic               hit_at_lock_o
);

    always_comb begin
        hit_any_o     = 1'b0;
        hit_off_o     = '0;
        hit_at_lock_o = 1'b0;
        // Descending scan so the lowest hitting offset is the one left standing.
        for (int k = SYM_C - 1; k >= 0; k--) begin
            if (is_comma(window_i[k +: SYM_C])) begin
                hit_any_o = 1'b1;
                hit_off_o = OFF_W'(k);
                if (align_offset_i == OFF_W'(k)) begin
                    hit_at_lock_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/comma_align_lock.sv
// K28.5 symbol aligner with lock hysteresis; COMMA_ALIGN_STATS_EN adds loss/realign counters.
// Latency 1 cycle data_in to data_out; in_valid low freezes all state and drops RxValid/Comma_pulse.
module comma_align_lock
    import comma_align_pkg::*;
#(
    parameter int SYM_W      = 10,
    parameter int LOCK_CNT   = 3,
    parameter int UNLOCK_CNT = 4,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SYM_W-1:0] data_in,
    input  logic             in_valid,
    input  logic             detect_comma,
    output logic [SYM_W-1:0] data_out,
    output logic             RxValid,
    output logic             Comma_pulse,
    output logic [OFF_W-1:0] align_offset,
    output logic             locked
`ifdef COMMA_ALIGN_STATS_EN
    ,
    output logic [15:0]      lock_loss_cnt,
    output logic [15:0]      realign_cnt
`endif
);

    logic [SYM_W-1:0]   prev_q;
    logic [SYM_W-1:0]   dout_q, dout_d;
    logic               rxv_q, rxv_d;
    logic               pulse_q, pulse_d;
    logic [OFF_W-1:0]   off_q, off_d;
    align_state_t       state_q, state_d;
    logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d, lock_inc;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d, err_inc;

    logic [2*SYM_W-1:0] window;
    logic               hit_any, hit_at_lock;
    logic [OFF_W-1:0]   hit_off;

    assign window = {data_in, prev_q};

    comma_search u_search (
        .window_i       (window),
        .align_offset_i (off_q),
        .hit_any_o      (hit_any),
        .hit_off_o      (hit_off),
        .hit_at_lock_o  (hit_at_lock)
    );

    assign lock_inc = (lock_cnt_q == {CNT_W{1'b1}}) ? lock_cnt_q : lock_cnt_q + 1'b1;
    assign err_inc  = (err_cnt_q  == {CNT_W{1'b1}}) ? err_cnt_q  : err_cnt_q  + 1'b1;

    always_comb begin
        state_d    = state_q;
        off_d      = off_q;
        lock_cnt_d = lock_cnt_q;
        err_cnt_d  = err_cnt_q;
        pulse_d    = 1'b0;
        if (in_valid && detect_comma) begin
            case (state_q)
                UNLOCKED: begin
                    if (hit_any) begin
                        off_d      = hit_off;
                        lock_cnt_d = CNT_W'(1);
                        if (LOCK_CNT <= 1) begin
                            state_d   = LOCKED;
                            err_cnt_d = '0;
                        end else begin
                            state_d = CHECK;
                        end
                    end
                end
                CHECK: begin
                    // An aligned hit outranks a simultaneous hit elsewhere.
                    if (hit_at_lock) begin
                        lock_cnt_d = lock_inc;
                        if (lock_inc >= CNT_W'(LOCK_CNT)) begin
                            state_d   = LOCKED;
                            err_cnt_d = '0;
                        end
                    end else if (hit_any) begin
                        off_d      = hit_off;
                        lock_cnt_d = CNT_W'(1);
                    end
                end
                LOCKED: begin
                    if (hit_at_lock) begin
                        err_cnt_d = '0;
                        pulse_d   = 1'b1;
                    end else if (hit_any) begin
                        err_cnt_d = err_inc;
                        if (err_inc >= CNT_W'(UNLOCK_CNT)) begin
                            state_d    = UNLOCKED;
                            lock_cnt_d = '0;
                        end
                    end
                end
                default: state_d = UNLOCKED;
            endcase
        end
    end

    // off_d only differs from off_q when a new offset is accepted, so it is the effective offset.
    always_comb begin
        dout_d = window[SYM_W-1:0];
        for (int k = 0; k < SYM_W; k++) begin
            if (off_d == OFF_W'(k)) begin
                dout_d = window[k +: SYM_W];
            end
        end
    end

    assign rxv_d = in_valid && (state_d == LOCKED);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q     <= '0;
            dout_q     <= '0;
            rxv_q      <= 1'b0;
            pulse_q    <= 1'b0;
            off_q      <= '0;
            state_q    <= UNLOCKED;
            lock_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            rxv_q   <= rxv_d;
            pulse_q <= pulse_d;
            if (in_valid) begin
                prev_q     <= data_in;
                dout_q     <= dout_d;
                off_q      <= off_d;
                state_q    <= state_d;
                lock_cnt_q <= lock_cnt_d;
                err_cnt_q  <= err_cnt_d;
            end
        end
    end

    assign data_out     = dout_q;
    assign RxValid      = rxv_q;
    assign Comma_pulse  = pulse_q;
    assign align_offset = off_q;
    assign locked       = (state_q == LOCKED);

`ifdef COMMA_ALIGN_STATS_EN
    logic [15:0] loss_q, realign_q;
    logic        loss_ev, realign_ev;

    assign loss_ev    = (state_q == LOCKED) && (state_d == UNLOCKED);
    assign realign_ev = in_valid && detect_comma && (state_q == CHECK) && hit_any && !hit_at_lock;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q    <= '0;
            realign_q <= '0;
        end else begin
            if (loss_ev && (loss_q != 16'hFFFF)) begin
                loss_q <= loss_q + 16'd1;
            end
            if (realign_ev && (realign_q != 16'hFFFF)) begin
                realign_q <= realign_q + 16'd1;
            end
        end
    end

    assign lock_loss_cnt = loss_q;
    assign realign_cnt   = realign_q;
`endif

endmodule

// File: tb/tb_comma_align_lock.sv
// Directed bench for comma_align_lock: builds bit-shifted K28.5/D21.5 streams and checks alignment and lock.
module tb_comma_align_lock;
    import comma_align_pkg::*;

    localparam logic [9:0] DS = 10'h2AA;
    localparam logic [9:0] KP = 10'h0FA;
    localparam logic [9:0] KN = 10'h305;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] data_in = '0;
    logic       in_valid = 1'b0;
    logic       detect_comma = 1'b0;
    logic [9:0] data_out;
    logic       RxValid;
    logic       Comma_pulse;
    logic [3:0] align_offset;
    logic       locked;
`ifdef COMMA_ALIGN_STATS_EN
    logic [15:0] lock_loss_cnt;
    logic [15:0] realign_cnt;
`endif

    int         total = 0;
    int         bad = 0;
    int         sh = 0;
    logic [9:0] last_sym = DS;
    logic       det = 1'b1;

    always #5 clk = ~clk;

    comma_align_lock dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .data_in      (data_in),
        .in_valid     (in_valid),
        .detect_comma (detect_comma),
        .data_out     (data_out),
        .RxValid      (RxValid),
        .Comma_pulse  (Comma_pulse),
        .align_offset (align_offset),
        .locked       (locked)
`ifdef COMMA_ALIGN_STATS_EN
        ,
        .lock_loss_cnt(lock_loss_cnt),
        .realign_cnt  (realign_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Symbol sits at bit offset sh of the window once the following word arrives.
    task automatic send(input logic [9:0] sym);
        logic [19:0] pair;
        pair         = {sym, last_sym} >> (10 - sh);
        data_in      = pair[9:0];
        last_sym     = sym;
        in_valid     = 1'b1;
        detect_comma = det;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        data_in  = '0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        last_sym = DS;
        det      = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_dout",   32'(data_out), 32'h0);
        chk("rst_rxv",    32'(RxValid), 32'h0);
        chk("rst_pulse",  32'(Comma_pulse), 32'h0);
        chk("rst_off",    32'(align_offset), 32'h0);
        chk("rst_locked", 32'(locked), 32'h0);

        // Offset 0: repeated K28.5+ words
        sh = 0;
        send(DS); chk("a_dout0", 32'(data_out), 32'h0);
        send(KP); chk("a_dout1", 32'(data_out), 32'(DS));
        send(KP); chk("a_dout2", 32'(data_out), 32'(KP));
                  chk("a_lk1", 32'(locked), 32'h0);
        send(KP); chk("a_lk2", 32'(locked), 32'h0);
        send(KP); chk("a_lk3", 32'(locked), 32'h1);
                  chk("a_rxv", 32'(RxValid), 32'h1);
                  chk("a_pls0", 32'(Comma_pulse), 32'h0);
                  chk("a_off", 32'(align_offset), 32'h0);
        send(KP); chk("a_pls1", 32'(Comma_pulse), 32'h1);
        send(DS); chk("a_pls2", 32'(Comma_pulse), 32'h1);
                  chk("a_dout3", 32'(data_out), 32'(KP));
        send(DS); chk("a_pls3", 32'(Comma_pulse), 32'h0);
                  chk("a_dout4", 32'(data_out), 32'(DS));

        // Offset 3: alternating disparity commas with D21.5 between
        do_reset();
        sh = 3;
        send(DS); send(KP);
        send(DS); chk("b_off", 32'(align_offset), 32'h3);
                  chk("b_dP", 32'(data_out), 32'(KP));
                  chk("b_lk0", 32'(locked), 32'h0);
        send(KN); chk("b_dD", 32'(data_out), 32'(DS));
        send(DS); chk("b_dN", 32'(data_out), 32'(KN));
        send(KP); chk("b_lk1", 32'(locked), 32'h0);
        send(DS); chk("b_lk2", 32'(locked), 32'h1);
                  chk("b_dP2", 32'(data_out), 32'(KP));
                  chk("b_rxv", 32'(RxValid), 32'h1);
        send(DS); chk("b_dD2", 32'(data_out), 32'(DS));

        // Misaligned commas at offset 7 while locked at 3
        sh = 7;
        send(DS); send(KP);
        send(DS); chk("c_e1", 32'(locked), 32'h1);
        send(KP);
        send(DS); chk("c_e2", 32'(locked), 32'h1);
        sh = 3;
        send(DS); send(KP);
        send(DS); chk("c_ok_pls", 32'(Comma_pulse), 32'h1);
                  chk("c_ok_lk", 32'(locked), 32'h1);
        sh = 7;
        send(DS);
        send(KP); send(DS);
        send(KP); send(DS);
        send(KP); send(DS); chk("c_e3", 32'(locked), 32'h1);
                            chk("c_e3_pls", 32'(Comma_pulse), 32'h0);
        send(KP); send(DS); chk("c_e4", 32'(locked), 32'h0);
                            chk("c_e4_rxv", 32'(RxValid), 32'h0);
                            chk("c_e4_off", 32'(align_offset), 32'h3);
`ifdef COMMA_ALIGN_STATS_EN
        chk("c_loss_cnt", 32'(lock_loss_cnt), 32'h1);
`endif

        // Realign inside CHECK: offset 2 then 5
        do_reset();
        sh = 2;
        send(DS); send(KP); send(DS); send(KP);
        send(DS); chk("d_off2", 32'(align_offset), 32'h2);
                  chk("d_lk0", 32'(locked), 32'h0);
        sh = 5;
        send(DS); send(KP);
        send(DS); chk("d_off5", 32'(align_offset), 32'h5);
                  chk("d_dP", 32'(data_out), 32'(KP));
                  chk("d_lk1", 32'(locked), 32'h0);
        send(KP);
        send(DS); chk("d_lk2", 32'(locked), 32'h0);
        send(KP);
        send(DS); chk("d_lk3", 32'(locked), 32'h1);
`ifdef COMMA_ALIGN_STATS_EN
        chk("d_realign_cnt", 32'(realign_cnt), 32'h1);
`endif

        // in_valid gap with a comma straddling the gap
        send(KP); chk("e_dD", 32'(data_out), 32'(DS));
        in_valid = 1'b0;
        data_in  = 10'h3FF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("e_rxv", 32'(RxValid), 32'h0);
            chk("e_pls", 32'(Comma_pulse), 32'h0);
            chk("e_dout", 32'(data_out), 32'(DS));
            chk("e_lk", 32'(locked), 32'h1);
        end
        send(DS); chk("e_res_pls", 32'(Comma_pulse), 32'h1);
                  chk("e_res_rxv", 32'(RxValid), 32'h1);
                  chk("e_res_dout", 32'(data_out), 32'(KP));
                  chk("e_res_off", 32'(align_offset), 32'h5);

        // Asynchronous reset while locked, then search disabled, then relock
        #2;
        rst_n = 1'b0;
        #1;
        chk("f_rst_lk", 32'(locked), 32'h0);
        chk("f_rst_dout", 32'(data_out), 32'h0);
        chk("f_rst_off", 32'(align_offset), 32'h0);
        chk("f_rst_rxv", 32'(RxValid), 32'h0);
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        last_sym = DS;
        sh       = 0;
        det      = 1'b0;
        send(DS); send(KP); send(KP);
        send(KP); chk("f_nodet_lk", 32'(locked), 32'h0);
                  chk("f_nodet_dout", 32'(data_out), 32'(KP));
        det = 1'b1;
        send(KP);
        send(KP); chk("f_relock2", 32'(locked), 32'h0);
        send(KP); chk("f_relock3", 32'(locked), 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
